// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, fault codes and monitor state shared by the conflict monitor
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  typedef enum logic [2:0] {
    FLT_NONE         = 3'd0,
    FLT_ILLEGAL      = 3'd1,
    FLT_CONFLICT     = 3'd2,
    FLT_ORDER        = 3'd3,
    FLT_SHORT_GREEN  = 3'd4,
    FLT_SHORT_YELLOW = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    STARTUP,
    NORMAL,
    FAULT
  } mon_state_t;

  function automatic logic is_legal_light(input logic [2:0] code);
    return (code == LIGHT_GREEN) || (code == LIGHT_YELLOW) || (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/approach_phase_timer.sv
// rtl/approach_phase_timer.sv - per-approach code history, duration counter and phase checks
module approach_phase_timer
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_MIN = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [2:0] i_code,
  output logic       o_illegal,
  output logic       o_order_err,
  output logic       o_short_green,
  output logic       o_short_yellow,
  output logic       o_non_red
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] Y_MIN   = CNT_W'(YELLOW_MIN);

  logic [2:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exempt;
  logic             w_change;
  logic             w_allowed;

  assign w_change  = (i_code != r_prev);
  assign w_allowed = ((r_prev == LIGHT_GREEN)  && (i_code == LIGHT_YELLOW)) ||
                     ((r_prev == LIGHT_YELLOW) && (i_code == LIGHT_RED))    ||
                     ((r_prev == LIGHT_RED)    && (i_code == LIGHT_GREEN));

  assign o_illegal      = !is_legal_light(i_code);
  assign o_non_red      = (i_code != LIGHT_RED);
  assign o_order_err    = i_run && w_change && !w_allowed;
  // The phase in progress at startup has an unknown start, so its length is not judged.
  assign o_short_green  = i_run && !r_exempt && (r_prev == LIGHT_GREEN) &&
                          (i_code == LIGHT_YELLOW) && (r_cnt < G_MIN);
  assign o_short_yellow = i_run && !r_exempt && (r_prev == LIGHT_YELLOW) &&
                          (i_code == LIGHT_RED) && (r_cnt < Y_MIN);

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_prev   <= LIGHT_RED;
      r_cnt    <= '0;
      r_exempt <= 1'b1;
    end else if (i_load) begin
      r_prev   <= i_code;
      r_cnt    <= CNT_ONE;
      r_exempt <= 1'b1;
    end else if (i_run) begin
      if (w_change) begin
        r_prev   <= i_code;
        r_cnt    <= CNT_ONE;
        r_exempt <= 1'b0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - safety stage between the intersection controller and lamp drivers
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_MIN = 4,
  parameter int FLASH_DIV  = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights_in,
  input  logic [2:0] s_lights_in,
  input  logic [2:0] e_lights_in,
  input  logic [2:0] w_lights_in,
  input  logic       clr_fault,
  output logic [2:0] n_lights_out,
  output logic [2:0] s_lights_out,
  output logic [2:0] e_lights_out,
  output logic [2:0] w_lights_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int                 FLASH_W    = (FLASH_DIV > 1) ? $clog2(2 * FLASH_DIV) : 1;
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
  localparam logic [FLASH_W-1:0] FLASH_HALF = FLASH_W'(FLASH_DIV);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_DIV - 1);
  localparam logic [3:0][2:0]    ALL_RED    = {4{LIGHT_RED}};
  localparam logic [3:0][2:0]    ALL_YELLOW = {4{LIGHT_YELLOW}};
  localparam logic [3:0][2:0]    ALL_DARK   = {4{LIGHT_DARK}};

  mon_state_t         r_state, w_state_nxt;
  fault_code_t        r_code, w_code_nxt, w_viol;
  logic [3:0][2:0]    r_out, w_out_nxt;
  logic [FLASH_W-1:0] r_flash, w_flash_nxt;

  logic [3:0][2:0] w_in;
  logic [3:0]      w_illegal, w_order, w_short_g, w_short_y, w_non_red;
  logic            w_conflict;

  assign w_in = {n_lights_in, s_lights_in, e_lights_in, w_lights_in};

  for (genvar g = 0; g < 4; g++) begin : g_approach
    approach_phase_timer #(
      .GREEN_MIN (GREEN_MIN),
      .YELLOW_MIN(YELLOW_MIN),
      .CNT_W     (CNT_W)
    ) u_timer (
      .clk           (clk),
      .rst_a         (rst_a),
      .i_load        (r_state == STARTUP),
      .i_run         (r_state == NORMAL),
      .i_code        (w_in[g]),
      .o_illegal     (w_illegal[g]),
      .o_order_err   (w_order[g]),
      .o_short_green (w_short_g[g]),
      .o_short_yellow(w_short_y[g]),
      .o_non_red     (w_non_red[g])
    );
  end

  // More than one bit set means two approaches are showing non-red together.
  assign w_conflict = (w_non_red & (w_non_red - 4'd1)) != 4'd0;

  always_comb begin
    w_viol = FLT_NONE;
    if (|w_illegal)      w_viol = FLT_ILLEGAL;
    else if (w_conflict) w_viol = FLT_CONFLICT;
    else if (|w_order)   w_viol = FLT_ORDER;
    else if (|w_short_g) w_viol = FLT_SHORT_GREEN;
    else if (|w_short_y) w_viol = FLT_SHORT_YELLOW;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_out_nxt   = r_out;
    w_flash_nxt = r_flash;
    case (r_state)
      STARTUP, NORMAL: begin
        w_state_nxt = NORMAL;
        w_out_nxt   = (r_state == NORMAL) ? w_in : ALL_RED;
        if (w_viol != FLT_NONE) begin
          w_state_nxt = FAULT;
          w_code_nxt  = w_viol;
          w_out_nxt   = ALL_YELLOW;
          w_flash_nxt = FLASH_ONE;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          w_state_nxt = STARTUP;
          w_code_nxt  = FLT_NONE;
          w_out_nxt   = ALL_RED;
          w_flash_nxt = '0;
        end else begin
          w_out_nxt   = (r_flash < FLASH_HALF) ? ALL_YELLOW : ALL_DARK;
          w_flash_nxt = (r_flash == FLASH_LAST) ? '0 : r_flash + FLASH_ONE;
        end
      end
      default: w_state_nxt = STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      r_state <= STARTUP;
      r_code  <= FLT_NONE;
      r_out   <= ALL_RED;
      r_flash <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_out   <= w_out_nxt;
      r_flash <= w_flash_nxt;
    end
  end

  assign n_lights_out = r_out[3];
  assign s_lights_out = r_out[2];
  assign e_lights_out = r_out[1];
  assign w_lights_out = r_out[0];
  assign fault        = (r_state == FAULT);
  assign fault_code   = r_code;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - directed self-checking bench for traffic_conflict_monitor
module tb_traffic_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;
  localparam logic [11:0] ALLR = {R, R, R, R};
  localparam logic [11:0] ALLY = {Y, Y, Y, Y};
  localparam logic [11:0] ALLD = {D, D, D, D};

  logic       clk = 1'b0;
  logic       rst_a;
  logic [2:0] n_in, s_in, e_in, w_in;
  logic       clr;
  logic [2:0] n_out, s_out, e_out, w_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_conflict_monitor dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .n_lights_in (n_in),
    .s_lights_in (s_in),
    .e_lights_in (e_in),
    .w_lights_in (w_in),
    .clr_fault   (clr),
    .n_lights_out(n_out),
    .s_lights_out(s_out),
    .e_lights_out(e_out),
    .w_lights_out(w_out),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  assign obs = {n_out, s_out, e_out, w_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_l(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e, input logic [2:0] w);
    n_in = n; s_in = s; e_in = e; w_in = w;
  endtask

  task automatic recover();
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_l(R, R, R, R);
    step();
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    clr   = 1'b0;
    set_l(R, R, R, R);
    step();
    checks++;
    if (obs !== ALLR || fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL reset: out=%h fault=%b code=%0d, want out=%h fault=0 code=0", obs, fault, fault_code, ALLR);
    end
    rst_a = 1'b1;
    step();
    checks++;
    if (obs !== ALLR || fault !== 1'b0) begin
      errors++;
      $display("FAIL startup: out=%h fault=%b, want out=%h fault=0", obs, fault, ALLR);
    end
  endtask

  task automatic test_pass_through();
    logic [3:0][2:0] v;
    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 4; a++)
        for (int ph = 0; ph < 2; ph++)
          for (int c = 0; c < (ph == 0 ? 8 : 4); c++) begin
            v = {R, R, R, R};
            v[3-a] = (ph == 0) ? G : Y;
            set_l(v[3], v[2], v[1], v[0]);
            step();
            checks++;
            if (obs !== v || fault !== 1'b0) begin
              errors++;
              $display("FAIL pass_r%0d_a%0d_p%0d_c%0d: out=%h fault=%b, want out=%h fault=0", r, a, ph, c, obs, fault, v);
            end
          end
    set_l(R, R, R, R);
    step();
    checks++;
    if (obs !== ALLR || fault !== 1'b0) begin
      errors++;
      $display("FAIL pass_tail: out=%h fault=%b, want out=%h fault=0", obs, fault, ALLR);
    end
  endtask

  task automatic test_conflict_flash();
    logic [11:0] exp_out;
    set_l(G, R, G, R);
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2 || obs !== ALLY) begin
      errors++;
      $display("FAIL conflict_entry: out=%h fault=%b code=%0d, want out=%h fault=1 code=2", obs, fault, fault_code, ALLY);
    end
    for (int i = 1; i < 12; i++) begin
      step();
      exp_out = ((i % 8) < 4) ? ALLY : ALLD;
      checks++;
      if (obs !== exp_out || fault !== 1'b1 || fault_code !== 3'd2) begin
        errors++;
        $display("FAIL flash_%0d: out=%h fault=%b code=%0d, want out=%h fault=1 code=2", i, obs, fault, fault_code, exp_out);
      end
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (obs !== ALLR || fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL clr_over_violation: out=%h fault=%b code=%0d, want out=%h fault=0 code=0", obs, fault, fault_code, ALLR);
    end
  endtask

  task automatic test_short_phases();
    set_l(G, R, R, R);
    step();
    checks++;
    if (obs !== ALLR || fault !== 1'b0) begin
      errors++;
      $display("FAIL exempt_startup: out=%h fault=%b, want out=%h fault=0", obs, fault, ALLR);
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] code;
      code = (i < 2) ? G : (i < 6) ? Y : (i == 6) ? R : G;
      set_l(code, R, R, R);
      step();
      checks++;
      if (obs !== {code, R, R, R} || fault !== 1'b0) begin
        errors++;
        $display("FAIL exempt_seq_%0d: out=%h fault=%b, want out=%h fault=0", i, obs, fault, {code, R, R, R});
      end
    end
    for (int i = 0; i < 4; i++) begin
      set_l(G, R, R, R);
      step();
    end
    set_l(Y, R, R, R);
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4 || obs !== ALLY) begin
      errors++;
      $display("FAIL short_green: out=%h fault=%b code=%0d, want out=%h fault=1 code=4", obs, fault, fault_code, ALLY);
    end
    recover();
    for (int i = 0; i < 10; i++) begin
      set_l((i < 8) ? G : Y, R, R, R);
      step();
    end
    checks++;
    if (fault !== 1'b0 || obs !== {Y, R, R, R}) begin
      errors++;
      $display("FAIL green8_ok: out=%h fault=%b, want out=%h fault=0", obs, fault, {Y, R, R, R});
    end
    set_l(R, R, R, R);
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd5) begin
      errors++;
      $display("FAIL short_yellow: fault=%b code=%0d, want fault=1 code=5", fault, fault_code);
    end
    recover();
  endtask

  task automatic test_illegal_priority();
    set_l(3'b011, G, G, R);
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      errors++;
      $display("FAIL illegal_prio: fault=%b code=%0d, want fault=1 code=1", fault, fault_code);
    end
    recover();
  endtask

  task automatic test_order_and_clear();
    set_l(G, R, R, R);
    step();
    set_l(R, R, R, R);
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      errors++;
      $display("FAIL order: fault=%b code=%0d, want fault=1 code=3", fault, fault_code);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (obs !== ALLR || fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL clear: out=%h fault=%b code=%0d, want out=%h fault=0 code=0", obs, fault, fault_code, ALLR);
    end
    step();
    for (int i = 0; i < 13; i++) begin
      logic [2:0] code;
      code = (i < 8) ? G : (i < 12) ? Y : R;
      set_l(code, R, R, R);
      step();
      checks++;
      if (obs !== {code, R, R, R} || fault !== 1'b0) begin
        errors++;
        $display("FAIL legal_after_clr_%0d: out=%h fault=%b, want out=%h fault=0", i, obs, fault, {code, R, R, R});
      end
    end
    set_l(R, G, R, R);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (obs !== {R, G, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_normal: out=%h fault=%b, want out=%h fault=0", obs, fault, {R, G, R, R});
    end
  endtask

  task automatic test_reset_mid_fault();
    set_l(G, G, R, R);
    step();
    step();
    rst_a = 1'b0;
    #3;
    checks++;
    if (obs !== ALLY || fault !== 1'b1 || fault_code !== 3'd2) begin
      errors++;
      $display("FAIL rst_before_edge: out=%h fault=%b code=%0d, want out=%h fault=1 code=2", obs, fault, fault_code, ALLY);
    end
    step();
    checks++;
    if (obs !== ALLR || fault !== 1'b0 || fault_code !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_fault: out=%h fault=%b code=%0d, want out=%h fault=0 code=0", obs, fault, fault_code, ALLR);
    end
    rst_a = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_conflict_flash();
    test_short_phases();
    test_illegal_priority();
    test_order_and_clear();
    test_reset_mid_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
